// File: rtl/alu_mc_pkg.sv
// Shared types and constants for the multi-cycle ALU.
package alu_mc_pkg;

  typedef enum logic [2:0] {
    OpAdd  = 3'b000,
    OpSub  = 3'b001,
    OpAnd  = 3'b010,
    OpOr   = 3'b011,
    OpXor  = 3'b100,
    OpSlt  = 3'b101,
    OpMul  = 3'b110,
    OpRsvd = 3'b111
  } op_t;

  // Bit positions inside the {N, Z, C, V} flag vector.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDone
  } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags
  );

  // ALU side.
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface

// File: rtl/alu_mc_core.sv
// Single-cycle ALU datapath: ADD/SUB/AND/OR/XOR/SLT and the reserved op.
module alu_core
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_t              op_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;

  // Shared adder; SUB and SLT reuse it as a + ~b + 1.
  always_comb begin
    is_sub = (op_i == OpSub) || (op_i == OpSlt);
    b_eff  = is_sub ? ~b_i : b_i;
    sum    = {1'b0, a_i} + {1'b0, b_eff} + (WIDTH + 1)'(is_sub);
    ovf    = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
  end

  // Result select; C/V only survive for ADD/SUB, N/Z always follow the result.
  always_comb begin
    result_o = '0;
    flags_o  = '0;
    case (op_i)
      OpAdd, OpSub: begin
        result_o        = sum[WIDTH-1:0];
        flags_o[FLAG_C] = sum[WIDTH];
        flags_o[FLAG_V] = ovf;
      end
      OpAnd:   result_o = a_i & b_i;
      OpOr:    result_o = a_i | b_i;
      OpXor:   result_o = a_i ^ b_i;
      OpSlt:   result_o = {{(WIDTH - 1){1'b0}}, sum[WIDTH-1] ^ ovf};
      default: result_o = '0;
    endcase
    flags_o[FLAG_N] = result_o[WIDTH-1];
    flags_o[FLAG_Z] = (result_o == '0);
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, shift-add multiplier and output registers.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_mc_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;

  op_t                op_in;
  logic               in_ready;
  logic               accept;
  logic [WIDTH-1:0]   core_result;
  logic [3:0]         core_flags;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_step;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i     (bus.a),
    .b_i     (bus.b),
    .op_i    (op_in),
    .result_o(core_result),
    .flags_o (core_flags)
  );

  // Handshake: ready depends only on state, out_ready and reset, never on in_valid.
  always_comb begin
    op_in    = op_t'(bus.op);
    in_ready = rst_n && ((state_q == StIdle) || ((state_q == StDone) && bus.out_ready));
    accept   = bus.in_valid && in_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  // One shift-add step: conditionally add multiplicand to the high half, then shift right.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                ({1'b0, mcand_q} & {(WIDTH + 1){prod_q[0]}});
    prod_step = {mul_sum, prod_q[WIDTH-1:1]};
  end

  // Next-state logic; an accept (IDLE or DONE) overrides the plain transitions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    flags_d  = flags_q;

    case (state_q)
      StMul: begin
        prod_d = prod_step;
        if (cnt_q == CntLast) begin
          // Last iteration: the product is complete in prod_step, load it directly.
          cnt_d           = '0;
          result_d        = prod_step[WIDTH-1:0];
          flags_d         = '0;
          flags_d[FLAG_N] = prod_step[WIDTH-1];
          flags_d[FLAG_Z] = (prod_step[WIDTH-1:0] == '0);
          flags_d[FLAG_C] = |prod_step[2*WIDTH-1:WIDTH];
          state_d         = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: ;
    endcase

    if (accept) begin
      if (op_in == OpMul) begin
        state_d = StMul;
        cnt_d   = '0;
        prod_d  = {{WIDTH{1'b0}}, bus.b};
        mcand_d = bus.a;
      end else begin
        state_d  = StDone;
        result_d = core_result;
        flags_d  = core_flags;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, the next generation of the team's 32-bit combinational ALU. It generalises data width and extends the op set with XOR, signed set-less-than and an iterative shift-add multiply. Operands enter and results leave through valid/ready handshakes, so the block can sit between pipeline stages with backpressure. It reports N/Z/C/V flags registered alongside each result.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept an operand bundle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 MUL, 111 reserved.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- flags  out  4  registered {N, Z, C, V}.

## Operation
- Accept when in_valid && in_ready. a, b and op are captured in that cycle; later input changes are ignored.
- ADD: a+b. SUB: a+~b+1. C is the adder carry-out, so for SUB, C=1 means no borrow. V is signed overflow: operands have matching effective signs and the result sign differs.
- AND/OR/XOR: bitwise. C=0, V=0.
- SLT: result = 1 if signed a < signed b, else 0. Computed as N^V of the internal subtraction. Output flags: C=0, V=0.
- MUL: unsigned shift-add over a 2·WIDTH product register, one multiplier bit per cycle, WIDTH iterations.
  - result = product[WIDTH-1:0]. This equals the low half of the signed product as well.
  - C = |product[2·WIDTH-1:WIDTH]. V=0.
- Reserved op 111: result = 0, flags = {0,1,0,0}. Handled as a single-cycle op.
- For every op, N = result[WIDTH-1] and Z = (result == 0), both evaluated on the final result.
- FSM states:
  - IDLE: in_ready=1. On accept, go to MUL if op==MUL; otherwise compute, load result/flags, go to DONE.
  - MUL: in_ready=0. Iteration counter counts 0..WIDTH-1. After the last iteration, load result/flags and go to DONE.
  - DONE: out_valid=1, result/flags held stable.
    - out_ready=0: stay in DONE.
    - out_ready=1 with no new accept: go to IDLE.
    - out_ready=1 and in_valid=1 (in_ready = out_ready in DONE): accept the new bundle in the same cycle. A single-cycle op stays in DONE with the new result next cycle; MUL goes to MUL.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is a combinational function of state and out_ready only, never of in_valid.

## Timing
- Reset (rst_n low at a clock edge): state=IDLE, result=0, flags=0, out_valid=0, MUL counter and product cleared. in_ready is forced to 0 while rst_n is low.
- Reset mid-MUL or while in DONE: the in-flight op is discarded with no partial output. out_valid is 0 from the first edge with rst_n low.
- Single-cycle ops: out_valid rises on the edge after accept (latency 1). With out_ready held high, throughput is one op per cycle.
- MUL: out_valid rises WIDTH+1 edges after accept, i.e. 33 for WIDTH=32.
- Result and flags change only on load. They must not toggle while out_valid=1 && out_ready=0.
- Counter width is clog2(WIDTH). Wrap from WIDTH-1 terminates the MUL; the counter never free-runs.

## Structure
- Package alu_mc_pkg holds:
  - op_t enum (3 bits, codes above).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - state_t enum {IDLE, MUL, DONE}.
- Sub-module alu_core #(WIDTH): purely combinational single-cycle datapath covering ADD/SUB/AND/OR/XOR/SLT/reserved, outputting result and flags. The adder architecture is free.
- Top level alu_mc holds the FSM, handshake, MUL shift-add datapath and output registers.

## Test plan
- ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, flags N=1 Z=0 C=0 V=1, out_valid on the edge after accept.
- SUB a=5, b=5 -> 0, Z=1 C=1. SUB a=3, b=5 -> 0xFFFFFFFE, N=1 C=0 V=0. SLT a=0xFFFFFFFF, b=1 -> 1, flags 0000.
- MUL a=0x00010000, b=0x00010000 -> result 0, Z=1 C=1, out_valid exactly 33 edges after accept. MUL a=7, b=6 -> 42, C=0.
- Backpressure: hold out_ready=0 for 10 cycles after a result -> result/flags stable, in_ready=0. Then out_ready=1 with in_valid=1 and op=XOR, a=0xF0F0F0F0, b=0xFFFF0000 -> back-to-back accept, next result 0x0F0FF0F0, N=0.
- Reset mid-MUL: rst_n low at iteration 10 -> out_valid=0 and in_ready=0 during reset. After release, in_ready=1 and a fresh ADD 1+1 returns 2 with no stale MUL output.
- Reserved op 111 and parametrisation: rerun the ADD/MUL cases at WIDTH=8 (0x7F+1 -> 0x80 with V=1; MUL latency 9).
